// File: rtl/hazard_control_pkg.sv
// -----------------------------------------------------------------------------
// hazard_control_pkg
// Shared definitions for the pipeline hazard controller:
//   - register index width and the x0 index
//   - watchdog FSM state encoding
//   - per-cycle hazard action encoding
//   - hc_load_use(): load-use detection between the EX load and the ID reader
// -----------------------------------------------------------------------------
package hazard_control_pkg;

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        HC_RUN      = 2'd0,
        HC_MEM_WAIT = 2'd1,
        HC_TIMEOUT  = 2'd2
    } hc_state_e;

    // What the controller does to the pipe this cycle, after priority resolution.
    typedef enum logic [2:0] {
        ACT_NONE     = 3'd0,
        ACT_LOAD_USE = 3'd1,
        ACT_FLUSH    = 3'd2,
        ACT_FREEZE   = 3'd3,
        ACT_RESET    = 3'd4
    } hc_action_e;

    // A load in EX whose destination is read by the instruction in ID.
    // x0 is never a real dependency.
    function automatic logic hc_load_use(
        input logic     memread,
        input reg_idx_t ex_rd,
        input reg_idx_t rs1,
        input reg_idx_t rs2,
        input logic     uses_rs1,
        input logic     uses_rs2
    );
        logic hit_rs1;
        logic hit_rs2;
        hit_rs1 = uses_rs1 && (ex_rd == rs1);
        hit_rs2 = uses_rs2 && (ex_rd == rs2);
        return memread && (ex_rd != REG_ZERO) && (hit_rs1 || hit_rs2);
    endfunction

endpackage

// File: rtl/hazard_control_if.sv
// -----------------------------------------------------------------------------
// hazard_control_if
// Bundle between the pipeline (master) and the hazard controller (slave).
//   pipeline -> controller : id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
//                            id_ex_memread, id_ex_rd, ex_branch_taken, mem_busy
//   controller -> pipeline : pc_write, if_id_write, id_ex_bubble, if_id_flush,
//                            pipe_freeze, mem_timeout
// -----------------------------------------------------------------------------
interface hazard_control_if;
    import hazard_control_pkg::*;

    reg_idx_t id_rs1;
    reg_idx_t id_rs2;
    logic     id_uses_rs1;
    logic     id_uses_rs2;
    logic     id_ex_memread;
    reg_idx_t id_ex_rd;
    logic     ex_branch_taken;
    logic     mem_busy;

    logic     pc_write;
    logic     if_id_write;
    logic     id_ex_bubble;
    logic     if_id_flush;
    logic     pipe_freeze;
    logic     mem_timeout;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_ex_memread, id_ex_rd, ex_branch_taken, mem_busy,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush,
               pipe_freeze, mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_ex_memread, id_ex_rd, ex_branch_taken, mem_busy,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush,
               pipe_freeze, mem_timeout
    );

endinterface

// File: rtl/hazard_control_sat_counter.sv
// -----------------------------------------------------------------------------
// hc_sat_counter
// Saturating up-counter used for the memory watchdog and the perf counters.
//   clk     in   core clock
//   reset   in   synchronous active-high reset, clears the count
//   clr_i   in   synchronous clear (wins over inc_i)
//   inc_i   in   increment; holds at all-ones instead of wrapping
//   count_o out  current count [CNT_W-1:0]
// -----------------------------------------------------------------------------
module hc_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CNT_ZERO;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/hazard_control.sv
// -----------------------------------------------------------------------------
// hazard_control
// Pipeline hazard controller for the 5-stage RISC-V core. Resolves what the
// EX forwarding unit cannot: load-use stalls, taken-branch flushes and a
// full-pipe freeze while data memory is busy, with a memory-wait watchdog.
// Outputs are Mealy (state + current inputs) so hazards act in the cycle
// they are detected.
//   clk, reset          core clock, synchronous active-high reset
//   hc (slave)          hazard inputs from ID/EX/MEM, pipe control outputs
//   perf_lu_stalls      load-use stall cycles     (HAZARD_PERF_CNT_EN only)
//   perf_flushes        branch flush cycles       (HAZARD_PERF_CNT_EN only)
//   perf_freeze_cycles  memory freeze cycles      (HAZARD_PERF_CNT_EN only)
// Build option: define HAZARD_PERF_CNT_EN to add the saturating perf counters.
// -----------------------------------------------------------------------------
module hazard_control
    import hazard_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_lu_stalls,
    output logic [CNT_W-1:0] perf_flushes,
    output logic [CNT_W-1:0] perf_freeze_cycles,
`endif
    hazard_control_if.slave  hc
);

    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    hc_state_e        state_q;
    hc_state_e        state_d;
    logic             mem_timeout_q;
    logic             mem_timeout_d;
    logic             wd_inc_s;
    logic             wd_clr_s;
    logic [CNT_W-1:0] wd_cnt_s;
    logic             load_use_s;
    hc_action_e       action_s;

    assign load_use_s = hc_load_use(hc.id_ex_memread, hc.id_ex_rd, hc.id_rs1,
                                    hc.id_rs2, hc.id_uses_rs1, hc.id_uses_rs2);

    // Priority resolution: reset > mem_busy > branch > load-use. A wrong-path
    // load-use under a taken branch is dropped; anything under a freeze is
    // re-evaluated after release because EX is held.
    always_comb begin
        action_s = ACT_NONE;
        if (reset) begin
            action_s = ACT_RESET;
        end else if (hc.mem_busy) begin
            action_s = ACT_FREEZE;
        end else if (hc.ex_branch_taken) begin
            action_s = ACT_FLUSH;
        end else if (load_use_s) begin
            action_s = ACT_LOAD_USE;
        end else begin
            action_s = ACT_NONE;
        end
    end

    // Pipe control outputs decoded from the resolved action.
    always_comb begin
        hc.pc_write     = 1'b1;
        hc.if_id_write  = 1'b1;
        hc.id_ex_bubble = 1'b0;
        hc.if_id_flush  = 1'b0;
        hc.pipe_freeze  = 1'b0;
        case (action_s)
            ACT_NONE: begin
                hc.pc_write    = 1'b1;
                hc.if_id_write = 1'b1;
            end
            ACT_LOAD_USE: begin
                hc.pc_write     = 1'b0;
                hc.if_id_write  = 1'b0;
                hc.id_ex_bubble = 1'b1;
            end
            ACT_FLUSH: begin
                hc.if_id_flush  = 1'b1;
                hc.id_ex_bubble = 1'b1;
            end
            ACT_FREEZE: begin
                hc.pc_write    = 1'b0;
                hc.if_id_write = 1'b0;
                hc.pipe_freeze = 1'b1;
            end
            default: begin
                // Reset and any illegal encoding: hold PC/IF_ID, inject NOP.
                hc.pc_write     = 1'b0;
                hc.if_id_write  = 1'b0;
                hc.id_ex_bubble = 1'b1;
                hc.if_id_flush  = 1'b0;
                hc.pipe_freeze  = 1'b0;
            end
        endcase
    end

    // Watchdog FSM next state. wd_cnt counts consecutive busy cycles; the
    // RUN->MEM_WAIT increment takes it from 0 to 1 on the first busy cycle.
    always_comb begin
        state_d       = state_q;
        mem_timeout_d = mem_timeout_q;
        wd_inc_s      = 1'b0;
        wd_clr_s      = 1'b0;
        case (state_q)
            HC_RUN: begin
                if (hc.mem_busy) begin
                    state_d  = HC_MEM_WAIT;
                    wd_inc_s = 1'b1;
                end else begin
                    wd_clr_s = 1'b1;
                end
            end
            HC_MEM_WAIT: begin
                if (!hc.mem_busy) begin
                    state_d  = HC_RUN;
                    wd_clr_s = 1'b1;
                end else if (wd_cnt_s == WD_LIMIT) begin
                    state_d       = HC_TIMEOUT;
                    mem_timeout_d = 1'b1;
                    wd_inc_s      = 1'b1;
                end else begin
                    wd_inc_s = 1'b1;
                end
            end
            HC_TIMEOUT: begin
                if (!hc.mem_busy) begin
                    state_d  = HC_RUN;
                    wd_clr_s = 1'b1;
                end else begin
                    wd_inc_s = 1'b1;
                end
            end
            default: begin
                state_d  = HC_RUN;
                wd_clr_s = 1'b1;
            end
        endcase
    end

    // FSM state and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HC_RUN;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign hc.mem_timeout = mem_timeout_q;

    hc_sat_counter #(.CNT_W(CNT_W)) u_wd_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (wd_clr_s),
        .inc_i   (wd_inc_s),
        .count_o (wd_cnt_s)
    );

`ifdef HAZARD_PERF_CNT_EN
    hc_sat_counter #(.CNT_W(CNT_W)) u_perf_lu (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (1'b0),
        .inc_i   (action_s == ACT_LOAD_USE),
        .count_o (perf_lu_stalls)
    );

    hc_sat_counter #(.CNT_W(CNT_W)) u_perf_flush (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (1'b0),
        .inc_i   (action_s == ACT_FLUSH),
        .count_o (perf_flushes)
    );

    hc_sat_counter #(.CNT_W(CNT_W)) u_perf_freeze (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (1'b0),
        .inc_i   (action_s == ACT_FREEZE),
        .count_o (perf_freeze_cycles)
    );
`endif

endmodule

// File: tb/tb_hazard_control.sv
// -----------------------------------------------------------------------------
// tb_hazard_control
// Self-checking bench for hazard_control (MEM_TIMEOUT=4). Each driven cycle
// pushes the reference model's expected outputs to a scoreboard queue; the
// entry is popped and compared on the falling edge when the Mealy outputs
// have settled.
// -----------------------------------------------------------------------------
module tb_hazard_control;
    import hazard_control_pkg::*;

    localparam int MT    = 4;
    localparam int CNT_W = 16;

    typedef struct {
        string      tag;
        logic [5:0] exp;   // {pc_write, if_id_write, bubble, flush, freeze, timeout}
    } scb_entry_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   busy_run;
    logic to_flag;
    scb_entry_t scb_q[$];

    hazard_control_if hcif ();

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_lu_stalls;
    logic [CNT_W-1:0] perf_flushes;
    logic [CNT_W-1:0] perf_freeze_cycles;
`endif

    hazard_control #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset              (reset),
`ifdef HAZARD_PERF_CNT_EN
        .perf_lu_stalls     (perf_lu_stalls),
        .perf_flushes       (perf_flushes),
        .perf_freeze_cycles (perf_freeze_cycles),
`endif
        .hc                 (hcif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the pipe control for the current inputs.
    function automatic logic [5:0] model_out(input logic rst, input logic ld,
                                             input logic [4:0] ex_rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic u1,
                                             input logic u2, input logic br, input logic busy);
        logic lu;
        lu = ld && (ex_rd != 5'd0) && ((u1 && ex_rd == rs1) || (u2 && ex_rd == rs2));
        if (rst)       return {5'b00100, to_flag};
        else if (busy) return {5'b00001, to_flag};
        else if (br)   return {5'b11110, to_flag};
        else if (lu)   return {5'b00100, to_flag};
        else           return {5'b11000, to_flag};
    endfunction

    task automatic drive_cycle(input string tag, input logic rst, input logic ld,
                               input logic [4:0] ex_rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic br, input logic busy);
        scb_entry_t e;
        reset                = rst;
        hcif.id_ex_memread   = ld;
        hcif.id_ex_rd        = ex_rd;
        hcif.id_rs1          = rs1;
        hcif.id_rs2          = rs2;
        hcif.id_uses_rs1     = u1;
        hcif.id_uses_rs2     = u2;
        hcif.ex_branch_taken = br;
        hcif.mem_busy        = busy;
        e.tag = tag;
        e.exp = model_out(rst, ld, ex_rd, rs1, rs2, u1, u2, br, busy);
        scb_q.push_back(e);
        @(negedge clk);
        e = scb_q.pop_front();
        check_val(e.tag,
                  {26'd0, hcif.pc_write, hcif.if_id_write, hcif.id_ex_bubble,
                   hcif.if_id_flush, hcif.pipe_freeze, hcif.mem_timeout},
                  {26'd0, e.exp});
        @(posedge clk);
        // Watchdog model: count consecutive busy cycles, flag at MT.
        if (rst) begin
            busy_run = 0;
            to_flag  = 1'b0;
        end else if (busy) begin
            if (busy_run < 1000) busy_run = busy_run + 1;
            if (busy_run >= MT) to_flag = 1'b1;
        end else begin
            busy_run = 0;
        end
        #1;
    endtask

    task automatic idle(input string tag);
        drive_cycle(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        busy_run = 0;
        to_flag  = 1'b0;
        reset    = 1'b1;
        #1;

        // Reset state
        drive_cycle("rst0", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle("rst1", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_val("rst_state", 32'(dut.state_q), 32'(HC_RUN));
        idle("idle0");

        // Test 1: load-use on rs1, then normal
        drive_cycle("t1_lu",   1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle("t1_next", 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle("t1_rs2",  1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);

        // Test 2: no stall for x0 or unused operand
        drive_cycle("t2_x0",    1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle("t2_nouse", 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle("t2_diff",  1'b0, 1'b1, 5'd7, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);

        // Test 3: branch wins over load-use
        drive_cycle("t3_br_lu", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Test 4: freeze with branch pending, flush on release
        for (int i = 0; i < 3; i++)
            drive_cycle("t4_frz", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_cycle("t4_rel", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle("t4_idle");

        // Test 5: busy for 6 cycles trips the watchdog after the 4th; sticky
        for (int i = 0; i < 6; i++)
            drive_cycle("t5_busy", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle("t5_sticky0");
        idle("t5_sticky1");
        drive_cycle("t5_lu", 1'b0, 1'b1, 5'd3, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Test 6: reset while in MEM_WAIT, busy still high during reset
        drive_cycle("t6_busy", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_cycle("t6_busy", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_cycle("t6_rst",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("t6_state", 32'(dut.state_q), 32'(HC_RUN));
        check_val("t6_wd", 32'(dut.wd_cnt_s), 32'd0);
        check_val("t6_timeout", {31'd0, hcif.mem_timeout}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check_val("t6_perf_lu", 32'(perf_lu_stalls), 32'd0);
        check_val("t6_perf_fl", 32'(perf_flushes), 32'd0);
        check_val("t6_perf_fz", 32'(perf_freeze_cycles), 32'd0);
`endif
        // Fresh watchdog: 3 busy cycles must not time out
        for (int i = 0; i < 3; i++)
            drive_cycle("t6_rebusy", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle("t6_idle");

        // Random mix against the model
        for (int i = 0; i < 200; i++) begin
            drive_cycle("rand",
                        ($urandom_range(0, 39) == 0),
                        1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)),
                        ($urandom_range(0, 5) == 0),
                        ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
